alarm_interval_timer: RTL

Consumer side of the time-parameter store in the car-alarm design. It:

- Takes a start request and the interval the alarm FSM needs.
- Drives `interval` to the store and samples the returned 4-bit `value` (seconds).
- Counts the value down in second ticks from an internal prescaler.
- Pulses `expired` when the count reaches zero.

It sits between the alarm FSM and `time_parameter_reprogram`, which it reads.

---
 rtl/alarm_interval_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alarm_interval_timer.sv
// alarm_interval_timer
// Loads a seconds value from the time-parameter store for the interval the
// alarm FSM asks for, counts it down in one-second ticks derived from an
// internal prescaler, and pulses `expired` once the count reaches zero.
//
// Optional feature: define ALARM_TIMER_RESTART_EN to let a start request in
// LOAD, COUNT or EXPIRE abort the running interval and reload from the newly
// requested one. Without it, starts are honoured only in IDLE.
module alarm_interval_timer #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic       clk,
   input  logic       systemReset_n,
   input  logic       start_timer,
   input  logic [1:0] interval_req,
   input  logic [3:0] value,
   output logic [1:0] interval,
   output logic       busy,
   output logic       expired,
   output logic [3:0] remaining
);

   // Prescaler sizing; TICK_DIV >= 2 keeps this at least one bit wide.
   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);

`ifdef ALARM_TIMER_RESTART_EN
   localparam bit RestartEn = 1'b1;
`else
   localparam bit RestartEn = 1'b0;
`endif

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLoad   = 2'd1;
   localparam logic [1:0] StCount  = 2'd2;
   localparam logic [1:0] StExpire = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [1:0]    interval_q, interval_d;
   logic [3:0]    remaining_q, remaining_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          busy_q, busy_d;
   logic          expired_q, expired_d;
   logic          tick;

   // A tick is the wrap cycle of the prescaler while counting.
   assign tick = (state_q == StCount) && (presc_q == PresLast);

   // Next-state logic for the FSM, interval select, countdown and prescaler.
   always_comb begin
      state_d     = state_q;
      interval_d  = interval_q;
      remaining_d = remaining_q;
      presc_d     = presc_q;

      unique case (state_q)
         StIdle: begin
            if (start_timer) begin
               interval_d = interval_req;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            // interval_q has been stable for a full cycle, so value is valid.
            remaining_d = value;
            presc_d     = '0;
            state_d     = (value == 4'd0) ? StExpire : StCount;
         end
         StCount: begin
            if (tick) begin
               presc_d = '0;
               if (remaining_q != 4'd0) begin
                  remaining_d = remaining_q - 4'd1;
               end
               if (remaining_q <= 4'd1) begin
                  state_d = StExpire;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         StExpire: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Restart overrides whatever the current state would have done, so an
      // aborted interval never reaches EXPIRE and never pulses.
      if (RestartEn && start_timer && (state_q != StIdle)) begin
         interval_d = interval_req;
         presc_d    = '0;
         state_d    = StLoad;
      end
   end

   // Registered status outputs follow the next state so they stay Moore.
   always_comb begin
      busy_d    = (state_d != StIdle);
      expired_d = (state_d == StExpire);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge systemReset_n) begin
      if (!systemReset_n) begin
         state_q     <= StIdle;
         interval_q  <= 2'b00;
         remaining_q <= 4'd0;
         presc_q     <= '0;
         busy_q      <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         interval_q  <= interval_d;
         remaining_q <= remaining_d;
         presc_q     <= presc_d;
         busy_q      <= busy_d;
         expired_q   <= expired_d;
      end
   end

   assign interval  = interval_q;
   assign busy      = busy_q;
   assign expired   = expired_q;
   assign remaining = remaining_q;

endmodule
